// File: rtl/m6809_mem_pkg.sv
// Shared encodings and sizing helpers for the async memory bus initiator.
// The phase counter is sized to the longest of the setup/access/hold phases.
package m6809_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEF_T_SETUP  = 1;
    localparam int DEF_T_ACCESS = 2;
    localparam int DEF_T_HOLD   = 1;

    function automatic int phase_cnt_w(input int ts, input int ta, input int th);
        int m;
        m = ts;
        if (ta > m) m = ta;
        if (th > m) m = th;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int PHASE_CW = phase_cnt_w(DEF_T_SETUP, DEF_T_ACCESS, DEF_T_HOLD);

endpackage

// File: rtl/async_mem_initiator_if.sv
// Request/response and external memory bus signals of the initiator.
// master = the initiator itself, slave = CPU port plus memory device side.
interface async_mem_initiator_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_sel;
    logic [AW-1:0] mem_a;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] mem_din;
    logic          mem_wait;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, mem_din, mem_wait,
        output req_ready, rsp_valid, rsp_rdata, mem_sel, mem_a, mem_rd, mem_wr, mem_dout
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, mem_din, mem_wait,
        input  req_ready, rsp_valid, rsp_rdata, mem_sel, mem_a, mem_rd, mem_wr, mem_dout
    );
endinterface

// File: rtl/mem_phase_timer.sv
// Loadable phase down-counter; done is high while the current phase is in its last cycle.
// The count freezes at 1 while wait_gate is high, stretching the final access cycle.
module mem_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          wait_gate,
    output logic          done
);
    logic [CW-1:0] cnt;

    assign done = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!(done && wait_gate) && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/async_mem_initiator.sv
// Turns single-beat CPU requests into setup/access/hold cycles on the async memory bus.
// Response pulses T_SETUP+T_ACCESS+T_HOLD+1 cycles after accept (+ wait cycles); one request in flight.
module async_mem_initiator
    import m6809_mem_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_ACCESS = DEF_T_ACCESS,
    parameter int T_HOLD   = DEF_T_HOLD
) (
    input  logic                   clk,
    input  logic                   rst,
    async_mem_initiator_if.master  bus
);
    localparam int CW = phase_cnt_w(T_SETUP, T_ACCESS, T_HOLD);

    if (T_ACCESS < 1) begin : g_bad_t_access
        $error("async_mem_initiator: T_ACCESS must be at least 1");
    end

    state_t        state_q, state_nxt;
    logic          we_q, we_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [DW-1:0] wdata_q, wdata_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          rsp_nxt;
    logic          tmr_load, tmr_done;
    logic [CW-1:0] tmr_val;

    mem_phase_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .wait_gate ((state_q == ACCESS) && bus.mem_wait),
        .done      (tmr_done)
    );

    always_comb begin
        state_nxt = state_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rdata_nxt = bus.rsp_rdata;
        rsp_nxt   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    we_nxt    = bus.req_we;
                    addr_nxt  = bus.req_addr;
                    wdata_nxt = bus.req_wdata;
                    tmr_load  = 1'b1;
                    if (T_SETUP > 0) begin
                        state_nxt = SETUP;
                        tmr_val   = CW'(T_SETUP);
                    end else begin
                        state_nxt = ACCESS;
                        tmr_val   = CW'(T_ACCESS);
                    end
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_nxt = ACCESS;
                    tmr_load  = 1'b1;
                    tmr_val   = CW'(T_ACCESS);
                end
            end
            ACCESS: begin
                // mem_wait only matters in the last access cycle
                if (tmr_done && !bus.mem_wait) begin
                    if (!we_q) rdata_nxt = bus.mem_din;
                    if (T_HOLD > 0) begin
                        state_nxt = HOLD;
                        tmr_load  = 1'b1;
                        tmr_val   = CW'(T_HOLD);
                    end else begin
                        state_nxt = IDLE;
                        rsp_nxt   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_nxt = IDLE;
                    rsp_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_sel   <= 1'b0;
            bus.mem_a     <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_dout  <= '0;
        end else begin
            state_q       <= state_nxt;
            we_q          <= we_nxt;
            addr_q        <= addr_nxt;
            wdata_q       <= wdata_nxt;
            bus.req_ready <= (state_nxt == IDLE);
            bus.rsp_valid <= rsp_nxt;
            bus.rsp_rdata <= rdata_nxt;
            bus.mem_sel   <= (state_nxt != IDLE);
            bus.mem_a     <= (state_nxt != IDLE) ? addr_nxt : '0;
            bus.mem_rd    <= (state_nxt == ACCESS) && !we_nxt;
            bus.mem_wr    <= (state_nxt == ACCESS) && we_nxt;
            bus.mem_dout  <= (state_nxt != IDLE && we_nxt) ? wdata_nxt : '0;
        end
    end
endmodule

// File: tb/tb_async_mem_initiator.sv
// Scoreboarded bench: default-timing initiator plus a zero-setup/zero-hold variant.
module tb_async_mem_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] rd;
        int         cyc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    async_mem_initiator_if #(.AW(16), .DW(8)) ifa ();
    async_mem_initiator_if #(.AW(16), .DW(8)) ifb ();

    async_mem_initiator #(.AW(16), .DW(8), .T_SETUP(1), .T_ACCESS(2), .T_HOLD(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    async_mem_initiator #(.AW(16), .DW(8), .T_SETUP(0), .T_ACCESS(1), .T_HOLD(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    // memory model: fixed contents plus the last written location
    logic        wr_seen = 1'b0;
    logic [15:0] wr_addr = 16'h0;
    logic [7:0]  wr_data = 8'h0;
    always @(posedge clk) begin
        if (ifa.mem_wr) begin
            wr_seen <= 1'b1;
            wr_addr <= ifa.mem_a;
            wr_data <= ifa.mem_dout;
        end
    end

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h00FE: return 8'hFF;
            16'h0000: return 8'h4F;
            16'h0001: return 8'h4C;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign ifa.mem_din = !ifa.mem_rd ? 8'h00 :
                         (wr_seen && ifa.mem_a == wr_addr) ? wr_data : rom(ifa.mem_a);
    assign ifb.mem_din = ifb.mem_rd ? rom(ifb.mem_a) : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check_eq("rsp_a_unexpected", 32'(ifa.rsp_valid), 32'd0);
            end else begin
                ea = qa.pop_front();
                check_eq("rsp_a_rdata", 32'(ifa.rsp_rdata), 32'(ea.rd));
                check_eq("rsp_a_cycle", cyc, ea.cyc);
            end
        end
        if (ifb.rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check_eq("rsp_b_unexpected", 32'(ifb.rsp_valid), 32'd0);
            end else begin
                eb = qb.pop_front();
                check_eq("rsp_b_rdata", 32'(ifb.rsp_rdata), 32'(eb.rd));
                check_eq("rsp_b_cycle", cyc, eb.cyc);
            end
        end
        if (!rst) begin
            check_eq("strobe_a", 32'({ifa.mem_rd & ifa.mem_wr, (ifa.mem_rd | ifa.mem_wr) & ~ifa.mem_sel}), 32'd0);
            check_eq("strobe_b", 32'({ifb.mem_rd & ifb.mem_wr, (ifb.mem_rd | ifb.mem_wr) & ~ifb.mem_sel}), 32'd0);
        end
    end

    // One transaction on the default-timing initiator, checking the bus every cycle.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input int nwait, output int acc);
        int rsp_c, st_hi, guard;
        logic [31:0] obs, expv;
        exp_t e;
        rsp_c = 5 + nwait;
        st_hi = 3 + nwait;
        guard = 0;
        while (ifa.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_req", 32'(ifa.req_ready), 32'd1);
        acc = cyc;
        ifa.req_valid = 1'b1;
        ifa.req_we    = we;
        ifa.req_addr  = addr;
        ifa.req_wdata = wd;
        e.rd  = exp_rd;
        e.cyc = acc + rsp_c;
        qa.push_back(e);
        for (int k = 1; k <= rsp_c; k++) begin
            @(negedge clk);
            if (k == 1) ifa.req_valid = 1'b0;
            ifa.mem_wait = (k >= 3 && k < 3 + nwait);
            obs = 32'({ifa.mem_sel, ifa.mem_rd, ifa.mem_wr, ifa.mem_a, ifa.mem_dout});
            if (k < rsp_c)
                expv = 32'({1'b1, !we && k >= 2 && k <= st_hi, we && k >= 2 && k <= st_hi,
                            addr, we ? wd : 8'h00});
            else
                expv = 32'd0;
            check_eq($sformatf("bus_%s_%04h_c%0d", we ? "wr" : "rd", addr, k), obs, expv);
            if (k == rsp_c) check_eq("ready_at_rsp", 32'(ifa.req_ready), 32'd1);
        end
        ifa.mem_wait = 1'b0;
    endtask

    int acc1, acc2;

    initial begin
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0; ifa.mem_wait = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0; ifb.mem_wait = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_bus", 32'({ifa.mem_sel, ifa.mem_rd, ifa.mem_wr, ifa.mem_a, ifa.mem_dout}), 32'd0);
        check_eq("rst_rsp", 32'({ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata}), 32'd0);
        rst = 1'b0;
        #1 check_eq("ready_pre_edge", 32'(ifa.req_ready), 32'd0);
        @(posedge clk);
        #1 check_eq("ready_first_edge", 32'({ifa.req_ready, ifb.req_ready}), 32'd3);
        @(negedge clk);

        txn(1'b0, 16'h00FE, 8'h00, 8'hFF, 0, acc1);
        repeat (2) @(negedge clk);
        txn(1'b1, 16'h1234, 8'hA9, 8'hFF, 0, acc1);
        check_eq("mem_write", 32'({wr_addr, wr_data}), 32'({16'h1234, 8'hA9}));
        repeat (2) @(negedge clk);
        txn(1'b0, 16'h1234, 8'h00, 8'hA9, 3, acc1);
        repeat (2) @(negedge clk);
        txn(1'b0, 16'h0000, 8'h00, 8'h4F, 0, acc1);
        txn(1'b0, 16'h0001, 8'h00, 8'h4C, 0, acc2);
        check_eq("b2b_accept_gap", acc2 - acc1, 32'd5);
        repeat (2) @(negedge clk);

        // reset in the middle of a read: no response may follow
        check_eq("ready_rst_test", 32'(ifa.req_ready), 32'd1);
        ifa.req_valid = 1'b1; ifa.req_we = 1'b0; ifa.req_addr = 16'h00FE;
        @(negedge clk);
        ifa.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check_eq("rd_before_rst", 32'({ifa.mem_sel, ifa.mem_rd}), 32'd3);
        #1 rst = 1'b1;
        #1 check_eq("rst_mid_bus", 32'({ifa.mem_sel, ifa.mem_rd, ifa.mem_wr, ifa.mem_a, ifa.mem_dout}), 32'd0);
        check_eq("rst_mid_rsp", 32'({ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check_eq("ready_after_abort_pre", 32'(ifa.req_ready), 32'd0);
        @(posedge clk);
        #1 check_eq("ready_after_abort", 32'(ifa.req_ready), 32'd1);
        repeat (8) @(negedge clk);

        // zero setup / zero hold / single access cycle
        check_eq("b_ready", 32'(ifb.req_ready), 32'd1);
        ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_addr = 16'h00FE;
        eb.rd  = 8'hFF;
        eb.cyc = cyc + 2;
        qb.push_back(eb);
        @(negedge clk);
        ifb.req_valid = 1'b0;
        check_eq("b_c1", 32'({ifb.mem_sel, ifb.mem_rd, ifb.mem_wr, ifb.mem_a}), 32'({3'b110, 16'h00FE}));
        @(negedge clk);
        check_eq("b_c2", 32'({ifb.mem_sel, ifb.mem_rd, ifb.mem_wr, ifb.mem_a}), 32'd0);
        @(negedge clk);
        check_eq("b_c3", 32'({ifb.mem_sel, ifb.mem_rd, ifb.rsp_valid}), 32'd0);

        repeat (3) @(negedge clk);
        check_eq("sb_a_drained", qa.size(), 32'd0);
        check_eq("sb_b_drained", qb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
